// File: rtl/psw_ramp_seq.sv
// Header power-switch sequencer: staggers segment turn-on/turn-off with a latched gap
// so the rail decap absorbs each inrush step. Optional macro PSW_FAST_OFF_EN: one-edge turn-off.
module psw_ramp_seq #(
  parameter int NSEG = 4,
  parameter int DW   = 8
) (
  input  logic            ck,
  input  logic            rst,
  input  logic            pwr_req,
  input  logic [DW-1:0]   step_dly,
  output logic [NSEG-1:0] sw_en,
  output logic            pwr_ack,
  output logic            busy
);

  typedef enum logic [1:0] {S_OFF, S_RAMP_UP, S_ON, S_RAMP_DOWN} state_t;

  state_t          state_q, state_d;
  logic [NSEG-1:0] sw_en_q, sw_en_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   gap_q, gap_d;
  logic            pwr_ack_q, pwr_ack_d;
  logic            busy_q, busy_d;

  logic            expired;
  logic            full;
  logic [NSEG-1:0] sw_up, sw_dn;

  // Thermometer code: stepping up/down is a one-bit shift.
  assign expired = (cnt_q == '0);
  assign full    = &sw_en_q;
  assign sw_up   = {sw_en_q[NSEG-2:0], 1'b1};
  assign sw_dn   = {1'b0, sw_en_q[NSEG-1:1]};

  always_comb begin
    state_d = state_q;
    sw_en_d = sw_en_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_OFF: begin
        if (pwr_req) begin
          state_d = S_RAMP_UP;
          sw_en_d = NSEG'(1);
          gap_d   = step_dly;
          cnt_d   = step_dly;
        end
      end
      S_RAMP_UP: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pwr_req) begin
          if (full) begin
            // Settle interval done: rail is good.
            state_d = S_ON;
            cnt_d   = '0;
          end else begin
            sw_en_d = sw_up;
            cnt_d   = gap_q;
          end
        end else begin
`ifdef PSW_FAST_OFF_EN
          sw_en_d = '0;
          cnt_d   = '0;
          state_d = S_OFF;
`else
          sw_en_d = sw_dn;
          cnt_d   = gap_q;
          state_d = (sw_dn == '0) ? S_OFF : S_RAMP_DOWN;
`endif
        end
      end
      S_ON: begin
        if (!pwr_req) begin
          gap_d = step_dly;
`ifdef PSW_FAST_OFF_EN
          sw_en_d = '0;
          cnt_d   = '0;
          state_d = S_OFF;
`else
          sw_en_d = sw_dn;
          cnt_d   = step_dly;
          state_d = S_RAMP_DOWN;
`endif
        end
      end
      S_RAMP_DOWN: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!pwr_req) begin
          sw_en_d = sw_dn;
          cnt_d   = gap_q;
          state_d = (sw_dn == '0) ? S_OFF : S_RAMP_DOWN;
        end else begin
          sw_en_d = sw_up;
          cnt_d   = gap_q;
          state_d = S_RAMP_UP;
        end
      end
      default: begin
        state_d = S_OFF;
        sw_en_d = '0;
        cnt_d   = '0;
      end
    endcase
    pwr_ack_d = (state_d == S_ON);
    busy_d    = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= S_OFF;
      sw_en_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      pwr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_en_q   <= sw_en_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      pwr_ack_q <= pwr_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign sw_en   = sw_en_q;
  assign pwr_ack = pwr_ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_psw_ramp_seq.sv
// Self-checking bench for psw_ramp_seq: directed vector table, hand-written corner
// sequences, then random req/step_dly/rst against a segment-count reference model.
module tb_psw_ramp_seq;
  localparam int NSEG = 4;
  localparam int DW   = 8;
`ifdef PSW_FAST_OFF_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            ck = 1'b0;
  logic            rst = 1'b1;
  logic            req = 1'b0;
  logic [DW-1:0]   dly = '0;
  logic [NSEG-1:0] sw_en;
  logic            pwr_ack, busy;

  psw_ramp_seq #(.NSEG(NSEG), .DW(DW)) dut (
    .ck(ck), .rst(rst), .pwr_req(req), .step_dly(dly),
    .sw_en(sw_en), .pwr_ack(pwr_ack), .busy(busy)
  );

  always #5 ck = ~ck;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: number of segments on, ramp direction, cycles since last step.
  int m_lvl = 0, m_dir = 0, m_ack = 0, m_t = 0, m_g = 0;

  task automatic model_update();
    if (rst) begin
      m_lvl = 0; m_dir = 0; m_ack = 0; m_t = 0; m_g = 0;
    end else if (m_ack == 1) begin
      if (!req) begin
        m_g = int'(dly) + 1; m_t = 0; m_ack = 0;
        if (FAST) begin m_lvl = 0; m_dir = 0; end
        else begin m_lvl = NSEG - 1; m_dir = -1; end
      end
    end else if (m_dir == 0) begin
      if (req) begin
        m_g = int'(dly) + 1; m_t = 0; m_lvl = 1; m_dir = 1;
      end
    end else begin
      m_t++;
      if (m_t == m_g) begin
        m_t = 0;
        if (req) begin
          if (m_lvl == NSEG) begin m_ack = 1; m_dir = 0; end
          else begin m_lvl++; m_dir = 1; end
        end else if (FAST && m_dir == 1) begin
          m_lvl = 0; m_dir = 0;
        end else begin
          m_lvl--; m_dir = (m_lvl == 0) ? 0 : -1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge ck);
    model_update();
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string nm, input logic [NSEG-1:0] sw, input logic ack, input logic bz);
    n_chk++;
    if (sw_en !== sw || pwr_ack !== ack || busy !== bz) begin
      n_fail++;
      $display("FAIL %s: got sw_en=%b ack=%b busy=%b, want sw_en=%b ack=%b busy=%b",
               nm, sw_en, pwr_ack, busy, sw, ack, bz);
    end
  endtask

  typedef struct {
    logic            rst;
    logic            req;
    logic [DW-1:0]   dly;
    logic [NSEG-1:0] sw;
    logic            ack;
    logic            bz;
  } vec_t;

  function automatic vec_t mk(logic r, logic q, logic [DW-1:0] d, logic [NSEG-1:0] s, logic a, logic b);
    vec_t v;
    v.rst = r; v.req = q; v.dly = d; v.sw = s; v.ack = a; v.bz = b;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(1, 0, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(0, 0, 2, 4'b0000, 0, 0);
    tbl[2]  = mk(0, 1, 2, 4'b0001, 0, 1);  // E
    tbl[3]  = mk(0, 1, 2, 4'b0001, 0, 1);
    tbl[4]  = mk(0, 1, 2, 4'b0001, 0, 1);
    tbl[5]  = mk(0, 1, 2, 4'b0011, 0, 1);  // E+3
    tbl[6]  = mk(0, 1, 2, 4'b0011, 0, 1);
    tbl[7]  = mk(0, 1, 2, 4'b0011, 0, 1);
    tbl[8]  = mk(0, 1, 2, 4'b0111, 0, 1);  // E+6
    tbl[9]  = mk(0, 1, 2, 4'b0111, 0, 1);
    tbl[10] = mk(0, 1, 2, 4'b0111, 0, 1);
    tbl[11] = mk(0, 1, 2, 4'b1111, 0, 1);  // E+9
    tbl[12] = mk(0, 1, 2, 4'b1111, 0, 1);
    tbl[13] = mk(0, 1, 2, 4'b1111, 0, 1);
    tbl[14] = mk(0, 1, 2, 4'b1111, 1, 0);  // E+12
    tbl[15] = mk(0, 1, 2, 4'b1111, 1, 0);

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; dly = tbl[i].dly;
      step();
      chk($sformatf("tbl[%0d]", i), tbl[i].sw, tbl[i].ack, tbl[i].bz);
    end

    // Ramp down from ON, gap 3.
    req = 1'b0;
    step();
    if (FAST) chk("down_F", 4'b0000, 0, 0);
    else begin
      chk("down_F", 4'b0111, 0, 1);
      cyc(2); chk("down_F2", 4'b0111, 0, 1);
      cyc(1); chk("down_F3", 4'b0011, 0, 1);
      cyc(3); chk("down_F6", 4'b0001, 0, 1);
      cyc(3); chk("down_F9", 4'b0000, 0, 0);
    end
    cyc(2); chk("off_idle", 4'b0000, 0, 0);

    // step_dly=0: one step per edge.
    dly = 0; req = 1'b1;
    step(); chk("fast_E",  4'b0001, 0, 1);
    step(); chk("fast_E1", 4'b0011, 0, 1);
    step(); chk("fast_E2", 4'b0111, 0, 1);
    step(); chk("fast_E3", 4'b1111, 0, 1);
    step(); chk("fast_E4", 4'b1111, 1, 0);
    req = 1'b0;
    cyc(4); chk("fast_off", 4'b0000, 0, 0);

    // Reversal mid ramp-up.
    dly = 2; req = 1'b1;
    step(); chk("rev_E", 4'b0001, 0, 1);
    cyc(3); chk("rev_E3", 4'b0011, 0, 1);
    req = 1'b0;
    step(); chk("rev_E4", 4'b0011, 0, 1);
    step(); chk("rev_E5", 4'b0011, 0, 1);
    step();
    if (FAST) chk("rev_E6", 4'b0000, 0, 0);
    else chk("rev_E6", 4'b0001, 0, 1);
    cyc(3); chk("rev_E9", 4'b0000, 0, 0);

    // Synchronous reset mid-ramp, then fresh ramp with req still high.
    req = 1'b1;
    step(); chk("rst_E", 4'b0001, 0, 1);
    cyc(4);
    rst = 1'b1; step(); chk("rst_E5", 4'b0000, 0, 0);
    rst = 1'b0; step(); chk("rst_rel", 4'b0001, 0, 1);
    req = 1'b0;
    cyc(6); chk("rst_off", 4'b0000, 0, 0);

    // step_dly change mid-ramp is ignored until the next departure from ON.
    dly = 2; req = 1'b1;
    step(); dly = 7;
    cyc(3); chk("dly_E3", 4'b0011, 0, 1);
    cyc(2); chk("dly_E5", 4'b0011, 0, 1);
    cyc(1); chk("dly_E6", 4'b0111, 0, 1);
    cyc(6); chk("dly_E12", 4'b1111, 1, 0);
    req = 1'b0;
    step();
    if (!FAST) begin
      chk("dly_F", 4'b0111, 0, 1);
      cyc(7); chk("dly_F7", 4'b0111, 0, 1);
      cyc(1); chk("dly_F8", 4'b0011, 0, 1);
    end
    cyc(20); chk("dly_off", 4'b0000, 0, 0);

    // Maximum gap: 256 cycles per step, counter must not wrap.
    dly = 8'hFF; req = 1'b1;
    step(); chk("max_E", 4'b0001, 0, 1);
    dly = 0;
    cyc(255); chk("max_E255", 4'b0001, 0, 1);
    cyc(1); chk("max_E256", 4'b0011, 0, 1);
    req = 1'b0;
    cyc(600); chk("max_off", 4'b0000, 0, 0);

    // Random phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) req = ~req;
      if ($urandom_range(0, 7) == 0) dly = DW'($urandom_range(0, 4));
      rst = ($urandom_range(0, 299) == 0);
      step();
      chk($sformatf("rand[%0d]", i), NSEG'((1 << m_lvl) - 1), m_ack[0], (m_dir != 0));
      n_chk++;
      if (((sw_en + 1'b1) & sw_en) != '0 || (pwr_ack && sw_en != '1)) begin
        n_fail++;
        $display("FAIL inv[%0d]: got sw_en=%b ack=%b, want thermometer and ack->all-ones", i, sw_en, pwr_ack);
      end
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
